// File: rtl/reg_xfer_pkg.sv
// Shared types and constants for the register-to-register transfer sequencer.
// Imported by the arbiter and the sequencer top.
package reg_xfer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        LATCH,
        HOLD,
        ERR
    } state_t;

    localparam int NREG_DEFAULT = 8;
    localparam int NPORT        = 2;

endpackage

// File: rtl/reg_xfer_ctrl_if.sv
// Requester/register-bank signal bundle for reg_xfer_ctrl.
// The master side is the requester; the slave side is the sequencer.
interface reg_xfer_ctrl_if
    import reg_xfer_pkg::*;
#(
    parameter int NREG  = NREG_DEFAULT,
    parameter int SEL_W = $clog2(NREG)
);
    logic [NPORT-1:0] req_valid;
    logic [SEL_W-1:0] req_src0;
    logic [SEL_W-1:0] req_dst0;
    logic [SEL_W-1:0] req_src1;
    logic [SEL_W-1:0] req_dst1;
    logic [NPORT-1:0] req_ready;
    logic [NREG-1:0]  oen;
    logic [NREG-1:0]  cp;
    logic             busy;
    logic [NPORT-1:0] done;
    logic [NPORT-1:0] err;

    modport master (
        output req_valid, req_src0, req_dst0, req_src1, req_dst1,
        input  req_ready, oen, cp, busy, done, err
    );

    modport slave (
        input  req_valid, req_src0, req_dst0, req_src1, req_dst1,
        output req_ready, oen, cp, busy, done, err
    );
endinterface

// File: rtl/reg_xfer_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; grant is combinational, the last-grant
// pointer advances only when a granted request is actually accepted.
module rr_arb2
    import reg_xfer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [NPORT-1:0] i_req,
    input  logic             i_accept,
    output logic [NPORT-1:0] o_grant
);
    logic r_last;

    always_comb begin
        if (i_req == 2'b11) begin
            o_grant = r_last ? 2'b01 : 2'b10;
        end else begin
            o_grant = i_req;
        end
    end

    // Reset as if port 1 went last so port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_accept) begin
            r_last <= o_grant[1];
        end
    end
endmodule

// File: rtl/reg_xfer_ctrl.sv
// Sequences bus transfers between 74xx374-style registers: enables the source
// for DRIVE/LATCH/HOLD and pulses the destination load clock during LATCH.
module reg_xfer_ctrl
    import reg_xfer_pkg::*;
#(
    parameter int NREG  = NREG_DEFAULT,
    parameter int SEL_W = $clog2(NREG)
) (
    input  logic           clk,
    input  logic           rst,
    reg_xfer_ctrl_if.slave bus
);
    localparam logic [SEL_W:0] NREG_W = (SEL_W+1)'(NREG);

    state_t           r_state;
    logic [SEL_W-1:0] r_src;
    logic [SEL_W-1:0] r_dst;
    logic             r_port;
    logic [NREG-1:0]  r_oen;
    logic [NREG-1:0]  r_cp;
    logic             r_busy;
    logic [NPORT-1:0] r_done;
    logic [NPORT-1:0] r_err;

    logic [NPORT-1:0] w_grant;
    logic [NPORT-1:0] w_ready;
    logic             w_accept;
    logic             w_gport;
    logic [SEL_W-1:0] w_src;
    logic [SEL_W-1:0] w_dst;
    logic             w_legal;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (bus.req_valid),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    // Ready depends only on state and arbitration, never on the select fields.
    assign w_ready  = (r_state == IDLE && !rst) ? w_grant : '0;
    assign w_accept = |(bus.req_valid & w_ready);
    assign w_gport  = w_grant[1];
    assign w_src    = w_gport ? bus.req_src1 : bus.req_src0;
    assign w_dst    = w_gport ? bus.req_dst1 : bus.req_dst0;
    assign w_legal  = ({1'b0, w_src} < NREG_W) && ({1'b0, w_dst} < NREG_W)
                      && (w_src != w_dst);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_port  <= 1'b0;
            r_oen   <= '1;
            r_cp    <= '0;
            r_busy  <= 1'b0;
            r_done  <= '0;
            r_err   <= '0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_src  <= w_src;
                        r_dst  <= w_dst;
                        r_port <= w_gport;
                        r_busy <= 1'b1;
                        if (w_legal) begin
                            r_state <= DRIVE;
                            r_oen   <= ~(NREG'(1) << w_src);
                        end else begin
                            r_state <= ERR;
                            r_err   <= w_grant;
                        end
                    end
                end
                DRIVE: begin
                    r_state <= LATCH;
                    r_oen   <= ~(NREG'(1) << r_src);
                    r_cp    <= NREG'(1) << r_dst;
                end
                LATCH: begin
                    r_state <= HOLD;
                    r_cp    <= '0;
                    r_done  <= {r_port, ~r_port};
                end
                HOLD: begin
                    r_state <= IDLE;
                    r_oen   <= '1;
                    r_busy  <= 1'b0;
                end
                ERR: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_oen   <= '1;
                    r_cp    <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.oen       = r_oen;
    assign bus.cp        = r_cp;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Directed bench for reg_xfer_ctrl: an 8-register instance with a 374 bus
// model, plus a 6-register instance for out-of-range select handling.
module tb_reg_xfer_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_xfer_ctrl_if #(.NREG(8)) if8 ();
    reg_xfer_ctrl_if #(.NREG(6)) if6 ();

    reg_xfer_ctrl #(.NREG(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    reg_xfer_ctrl #(.NREG(6)) dut6 (.clk(clk), .rst(rst), .bus(if6));

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // 374 register contents for the 8-register bus.
    logic [7:0] regq [8] = '{8'hA0, 8'hA1, 8'h5A, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    logic [7:0] cp_prev = '0;
    logic [7:0] bus_v;

    function automatic logic [7:0] bus_val(input logic [7:0] oen);
        logic [7:0] b;
        b = 'x;
        if ($countones(~oen) == 1) begin
            for (int i = 0; i < 8; i++) if (!oen[i]) b = regq[i];
        end
        return b;
    endfunction

    always @(if8.cp) begin
        bus_v = bus_val(if8.oen);
        for (int i = 0; i < 8; i++) begin
            if (if8.cp[i] && !cp_prev[i]) begin
                check("bus_driven_at_cp", {31'b0, $isunknown(bus_v)}, 32'd0);
                regq[i] = bus_v;
            end
        end
        cp_prev = if8.cp;
    end

    function automatic logic inv_ok(input logic [7:0] oen, input logic [7:0] cp);
        logic ok;
        ok = ($countones(~oen) <= 1) && ($countones(cp) <= 1);
        if (cp != '0) ok = ok && ($countones(~oen) == 1) && ((cp & ~oen) == '0);
        return ok;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            check("inv8", {31'b0, inv_ok(if8.oen, if8.cp)}, 32'd1);
            check("inv6", {31'b0, inv_ok({2'b11, if6.oen}, {2'b00, if6.cp})}, 32'd1);
        end
    end

    typedef struct {
        bit         dsel;
        logic [1:0] valid;
        logic [3:0] s0, d0, s1, d1;
        logic [1:0] rdy;
        logic [7:0] oen, cp;
        logic       busy;
        logic [1:0] done, err;
    } vec_t;

    function automatic vec_t mk(input bit dsel, input logic [1:0] valid,
                                input logic [3:0] s0, input logic [3:0] d0,
                                input logic [3:0] s1, input logic [3:0] d1,
                                input logic [1:0] rdy, input logic [7:0] oen,
                                input logic [7:0] cp, input logic busy,
                                input logic [1:0] done, input logic [1:0] err);
        vec_t v;
        v.dsel = dsel; v.valid = valid;
        v.s0 = s0; v.d0 = d0; v.s1 = s1; v.d1 = d1;
        v.rdy = rdy; v.oen = oen; v.cp = cp; v.busy = busy; v.done = done; v.err = err;
        return v;
    endfunction

    // Inputs applied just after an edge; ready checked before the next edge,
    // registered outputs checked just after it.
    task automatic run_vec(input string tag, input int idx, input vec_t v);
        logic [7:0] oen_a, cp_a;
        logic [1:0] rdy_a, done_a, err_a;
        logic       busy_a;
        if (v.dsel) begin
            if6.req_valid = v.valid;
            if6.req_src0 = v.s0[2:0]; if6.req_dst0 = v.d0[2:0];
            if6.req_src1 = v.s1[2:0]; if6.req_dst1 = v.d1[2:0];
        end else begin
            if8.req_valid = v.valid;
            if8.req_src0 = v.s0[2:0]; if8.req_dst0 = v.d0[2:0];
            if8.req_src1 = v.s1[2:0]; if8.req_dst1 = v.d1[2:0];
        end
        #1;
        rdy_a = v.dsel ? if6.req_ready : if8.req_ready;
        check($sformatf("%s%0d.ready", tag, idx), {30'b0, rdy_a}, {30'b0, v.rdy});
        @(posedge clk); #1;
        if (v.dsel) begin
            oen_a = {2'b00, if6.oen}; cp_a = {2'b00, if6.cp};
            busy_a = if6.busy; done_a = if6.done; err_a = if6.err;
        end else begin
            oen_a = if8.oen; cp_a = if8.cp;
            busy_a = if8.busy; done_a = if8.done; err_a = if8.err;
        end
        check($sformatf("%s%0d.oen", tag, idx),  {24'b0, oen_a},  {24'b0, v.oen});
        check($sformatf("%s%0d.cp", tag, idx),   {24'b0, cp_a},   {24'b0, v.cp});
        check($sformatf("%s%0d.busy", tag, idx), {31'b0, busy_a}, {31'b0, v.busy});
        check($sformatf("%s%0d.done", tag, idx), {30'b0, done_a}, {30'b0, v.done});
        check($sformatf("%s%0d.err", tag, idx),  {30'b0, err_a},  {30'b0, v.err});
    endtask

    vec_t single_q[$];
    vec_t illegal_q[$];
    vec_t cont_q[$];
    vec_t after_q[$];

    initial begin
        single_q.push_back(mk(0, 2'b01, 2, 5, 0, 0, 2'b01, 8'hFB, 8'h00, 1, 2'b00, 2'b00));
        single_q.push_back(mk(0, 2'b00, 2, 5, 0, 0, 2'b00, 8'hFB, 8'h20, 1, 2'b00, 2'b00));
        single_q.push_back(mk(0, 2'b00, 2, 5, 0, 0, 2'b00, 8'hFB, 8'h00, 1, 2'b01, 2'b00));
        single_q.push_back(mk(0, 2'b00, 2, 5, 0, 0, 2'b00, 8'hFF, 8'h00, 0, 2'b00, 2'b00));

        illegal_q.push_back(mk(1, 2'b10, 0, 0, 3, 3, 2'b10, 8'h3F, 8'h00, 1, 2'b00, 2'b10));
        illegal_q.push_back(mk(1, 2'b10, 0, 0, 3, 6, 2'b00, 8'h3F, 8'h00, 0, 2'b00, 2'b00));
        illegal_q.push_back(mk(1, 2'b10, 0, 0, 3, 6, 2'b10, 8'h3F, 8'h00, 1, 2'b00, 2'b10));
        illegal_q.push_back(mk(1, 2'b10, 0, 0, 0, 5, 2'b00, 8'h3F, 8'h00, 0, 2'b00, 2'b00));
        illegal_q.push_back(mk(1, 2'b10, 0, 0, 0, 5, 2'b10, 8'h3E, 8'h00, 1, 2'b00, 2'b00));
        illegal_q.push_back(mk(1, 2'b00, 0, 0, 0, 5, 2'b00, 8'h3E, 8'h20, 1, 2'b00, 2'b00));
        illegal_q.push_back(mk(1, 2'b00, 0, 0, 0, 5, 2'b00, 8'h3E, 8'h00, 1, 2'b10, 2'b00));
        illegal_q.push_back(mk(1, 2'b00, 0, 0, 0, 5, 2'b00, 8'h3F, 8'h00, 0, 2'b00, 2'b00));

        for (int k = 0; k < 2; k++) begin
            cont_q.push_back(mk(0, 2'b11, 1, 3, 4, 6, 2'b01, 8'hFD, 8'h00, 1, 2'b00, 2'b00));
            cont_q.push_back(mk(0, 2'b11, 1, 3, 4, 6, 2'b00, 8'hFD, 8'h08, 1, 2'b00, 2'b00));
            cont_q.push_back(mk(0, 2'b11, 1, 3, 4, 6, 2'b00, 8'hFD, 8'h00, 1, 2'b01, 2'b00));
            cont_q.push_back(mk(0, 2'b11, 1, 3, 4, 6, 2'b00, 8'hFF, 8'h00, 0, 2'b00, 2'b00));
            cont_q.push_back(mk(0, 2'b11, 1, 3, 4, 6, 2'b10, 8'hEF, 8'h00, 1, 2'b00, 2'b00));
            cont_q.push_back(mk(0, 2'b11, 1, 3, 4, 6, 2'b00, 8'hEF, 8'h40, 1, 2'b00, 2'b00));
            cont_q.push_back(mk(0, 2'b11, 1, 3, 4, 6, 2'b00, 8'hEF, 8'h00, 1, 2'b10, 2'b00));
            cont_q.push_back(mk(0, 2'b11, 1, 3, 4, 6, 2'b00, 8'hFF, 8'h00, 0, 2'b00, 2'b00));
        end

        after_q.push_back(mk(0, 2'b01, 7, 0, 0, 0, 2'b01, 8'h7F, 8'h00, 1, 2'b00, 2'b00));
        after_q.push_back(mk(0, 2'b00, 7, 0, 0, 0, 2'b00, 8'h7F, 8'h01, 1, 2'b00, 2'b00));
        after_q.push_back(mk(0, 2'b00, 7, 0, 0, 0, 2'b00, 8'h7F, 8'h00, 1, 2'b01, 2'b00));
        after_q.push_back(mk(0, 2'b00, 7, 0, 0, 0, 2'b00, 8'hFF, 8'h00, 0, 2'b00, 2'b00));

        // Reset held for two cycles with port 0 already requesting.
        rst = 1'b1;
        if8.req_valid = 2'b01; if8.req_src0 = 3'd2; if8.req_dst0 = 3'd5;
        if8.req_src1 = '0; if8.req_dst1 = '0;
        if6.req_valid = 2'b00; if6.req_src0 = '0; if6.req_dst0 = '0;
        if6.req_src1 = '0; if6.req_dst1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.oen",   {24'b0, if8.oen},       32'hFF);
        check("rst.cp",    {24'b0, if8.cp},        32'h00);
        check("rst.ready", {30'b0, if8.req_ready}, 32'h0);
        check("rst.busy",  {31'b0, if8.busy},      32'h0);
        rst = 1'b0;
        #1;
        check("idle.ready", {30'b0, if8.req_ready}, 32'h1);

        foreach (single_q[i]) run_vec("single", i, single_q[i]);
        check("single.reg5", {24'b0, regq[5]}, 32'h5A);

        foreach (illegal_q[i]) run_vec("illegal", i, illegal_q[i]);

        // Fresh reset so the arbiter pointer favours port 0 again.
        if8.req_valid = 2'b00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        foreach (cont_q[i]) run_vec("cont", i, cont_q[i]);
        check("cont.reg3", {24'b0, regq[3]}, 32'hA1);
        check("cont.reg6", {24'b0, regq[6]}, 32'hA4);

        // Reset asserted while the transfer sits in LATCH.
        if8.req_valid = 2'b01; if8.req_src0 = 3'd2; if8.req_dst0 = 3'd5;
        @(posedge clk); #1;
        check("midrst.drive_oen", {24'b0, if8.oen}, 32'hFB);
        if8.req_valid = 2'b00;
        @(posedge clk); #1;
        check("midrst.latch_cp", {24'b0, if8.cp}, 32'h20);
        rst = 1'b1;
        #1;
        check("midrst.ready", {30'b0, if8.req_ready}, 32'h0);
        @(posedge clk); #1;
        check("midrst.oen",  {24'b0, if8.oen},  32'hFF);
        check("midrst.cp",   {24'b0, if8.cp},   32'h00);
        check("midrst.busy", {31'b0, if8.busy}, 32'h0);
        check("midrst.done", {30'b0, if8.done}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst.done_after", {30'b0, if8.done}, 32'h0);
        foreach (after_q[i]) run_vec("after", i, after_q[i]);
        check("after.reg0", {24'b0, regq[0]}, 32'hA7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
